alu_iterative: RTL



---
 rtl/alu_iterative.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/alu_iterative.sv
// Execute-stage ALU: logic, arithmetic, compare, pass-B and bit-serial shifts.
// Latency: 1 cycle from accept to out_valid for most ops; shamt+1 cycles for shifts with a nonzero amount.
// Backpressure: in_ready is high only in IDLE; the result is held in DONE until out_ready is seen.
// Ports: clk/reset (sync, active-high); in_valid/in_ready + Operation/SrcA/SrcB request side;
//        out_valid/out_ready + ALUResult/BranchTaken/Zero result side.
module alu_iterative #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            Operation,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] ALUResult,
    output logic                  BranchTaken,
    output logic                  Zero
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRL = 4'b0101;
    localparam logic [3:0] OP_SRA = 4'b0111;
    localparam logic [3:0] OP_EQ  = 4'b1000;
    localparam logic [3:0] OP_XOR = 4'b1001;
    localparam logic [3:0] OP_LUI = 4'b1010;
    localparam logic [3:0] OP_LT  = 4'b1100;
    localparam logic [3:0] OP_NE  = 4'b1101;
    localparam logic [3:0] OP_GE  = 4'b1110;

    localparam logic [SHAMT_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [SHAMT_WIDTH-1:0] CNT_ONE  = {{(SHAMT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              op_q, op_d;
    logic [DATA_WIDTH-1:0]   work_q, work_d;
    logic [SHAMT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   result_q, result_d;
    logic                    branch_q, branch_d;

    logic [SHAMT_WIDTH-1:0]  shamt;
    logic                    is_shift;
    logic [DATA_WIDTH-1:0]   alu_res;
    logic                    alu_br;
    logic [DATA_WIDTH-1:0]   step;

    assign shamt    = SrcB[SHAMT_WIDTH-1:0];
    assign is_shift = (Operation == OP_SLL) || (Operation == OP_SRL) || (Operation == OP_SRA);

    // Single-cycle result for everything except a shift by a nonzero amount;
    // a shift by zero reaches here and simply passes A through.
    always_comb begin
        alu_res = '0;
        alu_br  = 1'b0;
        unique case (Operation)
            OP_AND: alu_res = SrcA & SrcB;
            OP_OR:  alu_res = SrcA | SrcB;
            OP_ADD: alu_res = SrcA + SrcB;
            OP_SUB: alu_res = SrcA - SrcB;
            OP_XOR: alu_res = SrcA ^ SrcB;
            OP_SLL, OP_SRL, OP_SRA: alu_res = SrcA;
            OP_LT: begin
                alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
                alu_br  = alu_res[0];
            end
            OP_EQ: begin
                alu_res = {{(DATA_WIDTH-1){1'b0}}, (SrcA == SrcB)};
                alu_br  = alu_res[0];
            end
            OP_NE: begin
                alu_res = {{(DATA_WIDTH-1){1'b0}}, (SrcA != SrcB)};
                alu_br  = alu_res[0];
            end
            OP_GE: begin
                alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(SrcA) >= $signed(SrcB))};
                alu_br  = alu_res[0];
            end
            OP_LUI: alu_res = SrcB;
            default: begin
                alu_res = '0;
                alu_br  = 1'b0;
            end
        endcase
    end

    // One-bit shift of the working register in the latched direction.
    always_comb begin
        step = work_q;
        case (op_q)
            OP_SLL:  step = {work_q[DATA_WIDTH-2:0], 1'b0};
            OP_SRL:  step = {1'b0, work_q[DATA_WIDTH-1:1]};
            OP_SRA:  step = {work_q[DATA_WIDTH-1], work_q[DATA_WIDTH-1:1]};
            default: step = work_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        branch_d = branch_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (is_shift && (shamt != CNT_ZERO)) begin
                        state_d = S_SHIFT;
                        op_d    = Operation;
                        work_d  = SrcA;
                        cnt_d   = shamt;
                    end else begin
                        state_d  = S_DONE;
                        result_d = alu_res;
                        branch_d = alu_br;
                    end
                end
            end
            S_SHIFT: begin
                // result_q is untouched until the last step so Zero keeps
                // reflecting the previous completed result.
                work_d = step;
                cnt_d  = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d  = S_DONE;
                    result_d = step;
                    branch_d = 1'b0;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= OP_AND;
            work_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            branch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            branch_q <= branch_d;
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign ALUResult   = result_q;
    assign BranchTaken = branch_q;
    assign Zero        = (result_q == '0);

endmodule
